io_port_bank: RTL
=================

Name: io_port_bank

Overview:
Parametrised successor to the single-register input/output ports on the processor bus. It provides N_IN buffered input channels and N_OUT buffered output channels. Each channel has a DEPTH-entry first-word-fall-through FIFO, strobe/ready handshakes on the device side, and sticky overrun/underrun flags. It sits beside the register file: the selected input head drives the bus-mux input, and the output FIFOs are written from BusMuxOut under control-unit signals.

Parameters:
DATA_W, 32, data width of bus and every channel
N_IN, 4, number of input channels (1..16)
N_OUT, 2, number of output channels (1..16)
DEPTH, 4, entries per FIFO; power of two, >=2
SEL_W, 4, channel-select width; must satisfy 2**SEL_W >= max(N_IN, N_OUT)

Ports:
Clock  in  1  single system clock, rising edge
Clear  in  1  synchronous reset, active-low
In_Data  in  N_IN*DATA_W  device data; channel k occupies bits [k*DATA_W +: DATA_W]
In_Strobe  in  N_IN  device push request, per channel
In_Full  out  N_IN  input FIFO full, per channel
InSel  in  SEL_W  input channel addressed by INout
INout  in  1  drive the selected input head onto BusMuxIn_In and pop it
BusMuxIn_In  out  DATA_W  bus-mux input
InEmpty  out  1  selected input FIFO is empty (for control-unit polling)
BusMuxOut  in  DATA_W  processor bus
OutSel  in  SEL_W  output channel addressed by OutPortIn
OutPortIn  in  1  push BusMuxOut into the selected output FIFO
Out_Data  out  N_OUT*DATA_W  head of each output FIFO
Out_Valid  out  N_OUT  output FIFO non-empty
Out_Ready  in  N_OUT  device accepts head
Out_Full  out  N_OUT  output FIFO full
Overrun  out  N_IN+N_OUT  sticky flags; inputs in [N_IN-1:0], outputs above
Underrun  out  1  sticky: INout asserted while selected FIFO empty or InSel out of range
StatClr  in  1  clears Overrun and Underrun

Behaviour:
- All state updates occur on the rising edge of Clock.
- Clear=0 at an edge: all FIFO pointers and counts go to 0 and all flags go to 0; this aborts any in-flight operation.
  - Resulting outputs: In_Full=0, Out_Valid=0, Out_Full=0, InEmpty=1, BusMuxIn_In=0, Out_Data=0.
  - Clear has priority over every other input in that cycle.
- FIFO occupancy count is $clog2(DEPTH)+1 bits wide; read and write pointers wrap modulo DEPTH.
- Input push: In_Strobe[k]=1 at an edge writes In_Data slice k if the FIFO is not full, or if it is full and a pop of channel k occurs in the same cycle.
  - Otherwise the data is dropped and Overrun[k] is set.
- Input pop (combinational read, registered pop):
  - While INout=1, InSel<N_IN and that FIFO is non-empty, BusMuxIn_In = head word, and the head is popped at the edge.
  - Otherwise BusMuxIn_In = 0 and there is no pop.
  - If INout=1 and the selected FIFO is empty or InSel>=N_IN, Underrun is set at the edge.
  - Latency: a word strobed at edge t is readable from t+1.
  - Push and pop on an empty FIFO in the same cycle: the pop sees empty (zero data, Underrun set) and the push is accepted.
- Output push: OutPortIn=1 with OutSel<N_OUT writes BusMuxOut into FIFO OutSel if it is not full, or if the device pops it in the same cycle.
  - Otherwise the word is dropped and Overrun[N_IN+OutSel] is set.
  - OutPortIn with OutSel>=N_OUT is ignored and sets no flag.
- Output drain: Out_Valid[j] = count != 0; Out_Data slice j = head word when valid, else 0.
  - The head pops at the edge where Out_Valid[j] & Out_Ready[j].
  - Out_Ready while empty has no effect.
- Full flags are combinational from count == DEPTH. Simultaneous push and pop on a full FIFO keeps the count at DEPTH.
- Flags:
  - StatClr=1 clears all flags at the edge.
  - A flag-setting event in the same cycle as StatClr wins, so the flag is 1 after the edge.
- No combinational path from In_Strobe or Out_Ready to any output.

Decomposition:
- Shared package io_port_pkg: FIFO count-width helper function, flag-index offset constant (OUT_FLAG_BASE = N_IN).
- One sub-module, io_fifo (params DATA_W, DEPTH; ports push, pop, wdata, rdata, empty, full, overflow_evt), instantiated N_IN+N_OUT times via generate.
- Select decoding and flag logic stay in io_port_bank.

Test Plan:
- Reset mid-traffic: fill input channel 2 with 3 words, assert Clear=0 for one edge → In_Full=0, InEmpty=1 for InSel=2, Overrun=0, BusMuxIn_In=0.
- Input ordering: strobe ch1 with 0x11, 0x22, 0x33, 0x44, then INout with InSel=1 for 4 cycles → BusMuxIn_In = 0x11, 0x22, 0x33, 0x44, then InEmpty=1.
- Input overrun with simultaneous pop:
  - Fill ch0 to DEPTH=4, strobe 0xAA with no pop → dropped, Overrun[0]=1.
  - Strobe 0xBB with INout on the same edge → accepted, count stays 4, 0xBB is the last word read.
- Underrun and StatClr: INout with InSel=5 (N_IN=4) → BusMuxIn_In=0, Underrun=1 after the edge; StatClr → Underrun=0; StatClr together with a new underrun → Underrun=1.
- Output backpressure:
  - OutPortIn ch1 with 0x5, 0x6 while Out_Ready[1]=0 → Out_Valid[1]=1, Out_Data[1]=0x5.
  - Raise Out_Ready for 2 cycles → 0x5 then 0x6 delivered, then Out_Valid[1]=0, Out_Data[1]=0.
- Output overrun and pointer wrap: push 5 words to ch0 with Ready=0 → Out_Full[0]=1, Overrun[N_IN+0]=1. Drain all, then push and drain 8 more → order preserved across the wrap.

Source files
------------

// File: rtl/io_port_pkg.sv
// Shared helpers for the buffered I/O port bank: FIFO count sizing and the
// position of the output-channel flags inside the Overrun vector.
package io_port_pkg;

   function automatic int count_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   // Output-channel overrun flags sit directly above the input-channel flags.
   function automatic int out_flag_base(input int n_in);
      return n_in;
   endfunction

endpackage

// File: rtl/io_fifo.sv
// First-word-fall-through FIFO used by every channel; a push into a full
// FIFO is accepted only when a pop happens on the same edge.
module io_fifo
   import io_port_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              empty,
   output logic              full,
   output logic              overflow_evt
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = count_w(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  rd_ptr_q;
   logic [PTR_W-1:0]  wr_ptr_q;
   logic [CNT_W-1:0]  count_q;
   logic [CNT_W-1:0]  count_d;
   logic              do_pop;
   logic              do_push;

   assign empty        = (count_q == '0);
   assign full         = (count_q == CNT_W'(DEPTH));
   assign do_pop       = pop & ~empty;
   assign do_push      = push & (~full | do_pop);
   assign overflow_evt = push & ~do_push;
   assign rdata        = empty ? '0 : mem_q[rd_ptr_q];

   // NOTE: assign a default first so every path drives count_d and no latch is inferred.
   always_comb begin
      count_d = count_q;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         count_q <= count_d;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
   end

   // NOTE: storage is not reset; a zero count masks stale entries and rdata reads 0 when empty.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/io_port_bank.sv
// Bank of buffered input and output channels beside the register file:
// the selected input head feeds the bus mux, output FIFOs load from the bus.
module io_port_bank
   import io_port_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int N_IN   = 4,
   parameter int N_OUT  = 2,
   parameter int DEPTH  = 4,
   parameter int SEL_W  = 4
) (
   input  logic                      Clock,
   input  logic                      Clear,
   input  logic [N_IN*DATA_W-1:0]    In_Data,
   input  logic [N_IN-1:0]           In_Strobe,
   output logic [N_IN-1:0]           In_Full,
   input  logic [SEL_W-1:0]          InSel,
   input  logic                      INout,
   output logic [DATA_W-1:0]         BusMuxIn_In,
   output logic                      InEmpty,
   input  logic [DATA_W-1:0]         BusMuxOut,
   input  logic [SEL_W-1:0]          OutSel,
   input  logic                      OutPortIn,
   output logic [N_OUT*DATA_W-1:0]   Out_Data,
   output logic [N_OUT-1:0]          Out_Valid,
   input  logic [N_OUT-1:0]          Out_Ready,
   output logic [N_OUT-1:0]          Out_Full,
   output logic [N_IN+N_OUT-1:0]     Overrun,
   output logic                      Underrun,
   input  logic                      StatClr
);
   localparam int OUT_FLAG_BASE = out_flag_base(N_IN);
   localparam int N_FLAG        = N_IN + N_OUT;

   logic [N_IN-1:0]   in_pop;
   logic [N_IN-1:0]   in_empty;
   logic [DATA_W-1:0] in_rdata [N_IN];
   logic [N_OUT-1:0]  out_push;
   logic [N_OUT-1:0]  out_empty;
   logic [N_FLAG-1:0] ovf_evt;
   logic              sel_empty;
   logic [DATA_W-1:0] sel_head;
   logic [N_FLAG-1:0] overrun_q;
   logic [N_FLAG-1:0] overrun_d;
   logic              underrun_q;
   logic              underrun_d;

   for (genvar k = 0; k < N_IN; k++) begin : g_in
      assign in_pop[k] = INout && (InSel == SEL_W'(k));

      io_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
         .clk          (Clock),
         .rst_n        (Clear),
         .push         (In_Strobe[k]),
         .pop          (in_pop[k]),
         .wdata        (In_Data[k*DATA_W +: DATA_W]),
         .rdata        (in_rdata[k]),
         .empty        (in_empty[k]),
         .full         (In_Full[k]),
         .overflow_evt (ovf_evt[k])
      );
   end

   for (genvar j = 0; j < N_OUT; j++) begin : g_out
      assign out_push[j]  = OutPortIn && (OutSel == SEL_W'(j));
      assign Out_Valid[j] = ~out_empty[j];

      io_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
         .clk          (Clock),
         .rst_n        (Clear),
         .push         (out_push[j]),
         .pop          (Out_Ready[j]),
         .wdata        (BusMuxOut),
         .rdata        (Out_Data[j*DATA_W +: DATA_W]),
         .empty        (out_empty[j]),
         .full         (Out_Full[j]),
         .overflow_evt (ovf_evt[OUT_FLAG_BASE+j])
      );
   end

   // An out-of-range InSel looks like an empty channel, so it reads 0 and underruns.
   always_comb begin
      sel_empty = 1'b1;
      sel_head  = '0;
      for (int k = 0; k < N_IN; k++) begin
         if (InSel == SEL_W'(k)) begin
            sel_empty = in_empty[k];
            sel_head  = in_rdata[k];
         end
      end
   end

   assign InEmpty     = sel_empty;
   assign BusMuxIn_In = INout ? sel_head : '0;

   always_comb begin
      overrun_d  = (StatClr ? '0 : overrun_q) | ovf_evt;
      underrun_d = (StatClr ? 1'b0 : underrun_q) | (INout & sel_empty);
   end

   always_ff @(posedge Clock) begin
      if (!Clear) begin
         overrun_q  <= '0;
         underrun_q <= 1'b0;
      end else begin
         overrun_q  <= overrun_d;
         underrun_q <= underrun_d;
      end
   end

   assign Overrun  = overrun_q;
   assign Underrun = underrun_q;

endmodule
